// File: rtl/reg_streamcipher_pkg.sv
// reg_streamcipher_pkg: shared mode encoding and default geometry for the keystream generator
package reg_streamcipher_pkg;
    localparam int WIDTH_DEF = 8;
    localparam logic [7:0] TAPS_DEF = 8'b0001_1101;
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LFSR = 2'b01,
        MODE_ROT  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;
endpackage

// File: rtl/reg_streamcipher_lfsr_next.sv
// reg_streamcipher_lfsr_next: combinational LFSR step, shift right with tap parity into the MSB
// ports: q_i current state, q_o advanced state
module reg_streamcipher_lfsr_next
    import reg_streamcipher_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS = TAPS_DEF
) (
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] q_o
);
    assign q_o = {^(q_i & TAPS), q_i[WIDTH-1:1]};
endmodule

// File: rtl/reg_streamcipher.sv
// reg_streamcipher: keystream register with hold, LFSR advance, rotate-left and parallel seed load
// ports: clk, rst (async high), S1/S2 mode select, entrada seed, saida_d key bit = q[0]
module reg_streamcipher
    import reg_streamcipher_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS = TAPS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S1,
    input  logic             S2,
    input  logic [WIDTH-1:0] entrada,
    output logic             saida_d
);
    logic [WIDTH-1:0] q_q, q_d, lfsr_q;
    mode_e mode;
    assign mode = mode_e'({S1, S2});
    reg_streamcipher_lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next (.q_i(q_q), .q_o(lfsr_q));
    always_comb begin
        q_d = mode == MODE_LFSR ? lfsr_q :
              mode == MODE_ROT  ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
              mode == MODE_LOAD ? entrada : q_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end
    assign saida_d = q_q[0];
endmodule

// File: tb/tb_reg_streamcipher.sv
// tb_reg_streamcipher: randomized and directed checks of reg_streamcipher against a behavioural model
module tb_reg_streamcipher;
    logic clk = 0, rst = 1, S1 = 0, S2 = 0, saida_d;
    logic [7:0] entrada = 0;
    logic [7:0] m_q = 0;
    int passed = 0, total = 0;
    localparam string MSG_S = "Teste trabalho pratico sistemas logicos";
    reg_streamcipher dut (.clk(clk), .rst(rst), .S1(S1), .S2(S2), .entrada(entrada), .saida_d(saida_d));
    always #5 clk = ~clk;

    function automatic logic [7:0] model_next(input logic [7:0] q, input logic [1:0] m, input logic [7:0] e);
        int fb;
        fb = $countones(q & 8'h1D) % 2;
        case (m)
            2'b00: return q;
            2'b01: return 8'((q >> 1) + fb * 128);
            2'b10: return 8'((q * 2) % 256 + q / 128);
            default: return e;
        endcase
    endfunction

    task automatic step(input logic [1:0] m, input logic [7:0] e);
        {S1, S2} = m;
        entrada = e;
        @(posedge clk);
        #1;
        m_q = model_next(m_q, m, e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    endtask

    task automatic test_reset;
        #1;
        total++; if (saida_d !== 1'b0) $display("FAIL reset_out got %b want 0", saida_d); else passed++;
        {S1, S2} = 2'b11; entrada = 8'hFF;
        @(posedge clk); #1;
        total++; if (dut.q_q !== 8'h00) $display("FAIL reset_over_load got %h want 00", dut.q_q); else passed++;
        {S1, S2} = 2'b10;
        @(posedge clk); #1;
        total++; if (dut.q_q !== 8'h00) $display("FAIL reset_over_rot got %h want 00", dut.q_q); else passed++;
        rst = 0; m_q = 0;
        step(2'b11, 8'hA5);
        total++; if (saida_d !== 1'b1) $display("FAIL load_a5 got %b want 1", saida_d); else passed++;
        #2 rst = 1;
        #1;
        total++; if (saida_d !== 1'b0 || dut.q_q !== 8'h00)
            $display("FAIL async_reset got %b/%h want 0/00", saida_d, dut.q_q); else passed++;
        rst = 0; m_q = 0;
    endtask

    task automatic test_load_advance;
        logic [7:0] exp_q [5] = '{8'hF0, 8'hF8, 8'h7C, 8'hBE, 8'hDF};
        logic       exp_b [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        step(2'b11, 8'hF0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(2'b01, 8'h00);
            total++; if (dut.q_q !== exp_q[i] || saida_d !== exp_b[i])
                $display("FAIL load_adv[%0d] got %h/%b want %h/%b", i, dut.q_q, saida_d, exp_q[i], exp_b[i]); else passed++;
        end
    endtask

    task automatic test_round_trip;
        logic [311:0] msg, ct, pt;
        logic [7:0] k;
        msg = MSG_S;
        step(2'b11, 8'hF0);
        k = 8'hF0;
        for (int i = 0; i < 312; i++) begin
            ct[i] = msg[i] ^ saida_d;
            if (saida_d !== k[0]) begin
                total++; $display("FAIL key_enc[%0d] got %b want %b", i, saida_d, k[0]);
            end
            k = model_next(k, 2'b01, 8'h00);
            step(2'b01, 8'h00);
        end
        total++; if (ct === msg) $display("FAIL cipher_differs got %h want differ", ct[63:0]); else passed++;
        step(2'b11, 8'hF0);
        for (int i = 0; i < 312; i++) begin
            pt[i] = ct[i] ^ saida_d;
            step(2'b01, 8'h00);
        end
        total++; if (pt !== msg) $display("FAIL round_trip got %h want %h", pt[63:0], msg[63:0]); else passed++;
    endtask

    task automatic test_period;
        bit seen [256];
        bit ok = 1;
        step(2'b11, 8'h01);
        seen[1] = 1;
        for (int i = 1; i < 255; i++) begin
            step(2'b01, 8'h00);
            if (dut.q_q === 8'h00 || seen[dut.q_q] || dut.q_q !== m_q) ok = 0;
            seen[dut.q_q] = 1;
        end
        total++; if (!ok) $display("FAIL period_distinct got repeat/zero want 254 distinct nonzero"); else passed++;
        step(2'b01, 8'h00);
        total++; if (dut.q_q !== 8'h01) $display("FAIL period_return got %h want 01", dut.q_q); else passed++;
    endtask

    task automatic test_hold_rotate;
        step(2'b11, 8'h81);
        repeat (3) step(2'b00, 8'h55);
        total++; if (dut.q_q !== 8'h81) $display("FAIL hold got %h want 81", dut.q_q); else passed++;
        step(2'b10, 8'h55);
        total++; if (dut.q_q !== 8'h03 || saida_d !== 1'b1)
            $display("FAIL rotate got %h/%b want 03/1", dut.q_q, saida_d); else passed++;
    endtask

    task automatic test_zero_seed;
        bit ok = 1;
        step(2'b11, 8'h00);
        repeat (10) begin
            step(2'b01, 8'h00);
            if (saida_d !== 1'b0) ok = 0;
        end
        total++; if (!ok || dut.q_q !== 8'h00) $display("FAIL zero_seed got %h want 00", dut.q_q); else passed++;
    endtask

    task automatic test_random;
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1; #1 rst = 0;
                m_q = 0;
            end
            step(2'($urandom_range(0, 3)), 8'($urandom));
            if (dut.q_q !== m_q || saida_d !== m_q[0]) begin
                bad++;
                if (bad < 5) $display("FAIL random[%0d] got %h/%b want %h/%b", i, dut.q_q, saida_d, m_q, m_q[0]);
            end
        end
        total++; if (bad != 0) $display("FAIL random_total got %0d errors want 0", bad); else passed++;
    endtask

    initial begin
        test_reset;
        test_load_advance;
        test_round_trip;
        test_period;
        test_hold_rotate;
        test_zero_seed;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
